// File: rtl/decode_2_4_fifo.sv
// Buffered 2-to-4 decoder: {V,Y} words in, one-hot words out through a FIFO.
// Words with V=0 are consumed and counted, never queued.
module decode_2_4_fifo #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 Y,
  input  logic                       V,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 I,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNTW-1:0]            null_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CNTW-1:0] null_q, null_d;

  logic accept;
  logic push;
  logic pop;

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && V;
  assign pop       = out_valid && out_ready;

  assign I        = out_valid ? mem_q[rptr_q] : 4'b0000;
  assign level    = level_q;
  assign null_cnt = null_q;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    null_d  = null_q;
    // Y only reaches storage on a push, so an unknown Y with V=0 is harmless
    if (push) begin
      mem_d[wptr_q] = 4'b0001 << Y;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (accept && !V && (null_q != '1)) begin
      null_d = null_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'b0000;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      null_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      null_q  <= null_d;
    end
  end

endmodule

// File: tb/tb_decode_2_4_fifo.sv
// Directed bench for decode_2_4_fifo, with a second
// instance using a 2-bit null counter for saturation.
module tb_decode_2_4_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, V, out_ready;
  logic [1:0] Y;
  logic       in_ready, out_valid;
  logic [3:0] I;
  logic [2:0] level;
  logic [7:0] null_cnt;

  logic       b_in_valid, b_V, b_out_ready;
  logic [1:0] b_Y;
  logic       b_in_ready, b_out_valid;
  logic [3:0] b_I;
  logic [2:0] b_level;
  logic [1:0] b_null_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_2_4_fifo #(.DEPTH(4), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Y(Y), .V(V),
    .out_valid(out_valid), .out_ready(out_ready),
    .I(I), .level(level), .null_cnt(null_cnt)
  );

  decode_2_4_fifo #(.DEPTH(4), .CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .Y(b_Y), .V(b_V),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .I(b_I), .level(b_level), .null_cnt(b_null_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic v,
                       input logic [1:0] y);
    in_valid = iv;
    V        = v;
    Y        = y;
  endtask

  logic [1:0] yl [10];
  logic [3:0] e;

  initial begin
    yl = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2,
           2'd1, 2'd3, 2'd0, 2'd1, 2'd2};
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0);
    out_ready   = 1'b0;
    b_in_valid  = 1'b0;
    b_V         = 1'b0;
    b_Y         = 2'd0;
    b_out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_I", 32'(I), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_null", 32'(null_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // back-to-back decode with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'(i));
      step();
      e = 4'b0001 << i;
      chk("b2b_I", 32'(I), 32'(e));
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_level", 32'(level), 32'd1);
    end
    drive(1'b0, 1'b0, 2'd0);
    step();
    chk("b2b_drain_valid", 32'(out_valid), 32'd0);
    chk("b2b_drain_I", 32'(I), 32'd0);

    // fill to full with consumer stalled
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 2'd3); step();
    chk("fill_l1", 32'(level), 32'd1);
    chk("fill_I_hold", 32'(I), 32'h8);
    drive(1'b1, 1'b1, 2'd2); step();
    chk("fill_l2", 32'(level), 32'd2);
    drive(1'b1, 1'b1, 2'd1); step();
    chk("fill_l3", 32'(level), 32'd3);
    chk("fill_rdy3", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b1, 2'd0); step();
    chk("fill_l4", 32'(level), 32'd4);
    chk("full_rdy", 32'(in_ready), 32'd0);
    chk("full_I", 32'(I), 32'h8);
    drive(1'b1, 1'b1, 2'd2); step();
    chk("full_hold_l", 32'(level), 32'd4);
    chk("full_hold_I", 32'(I), 32'h8);
    out_ready = 1'b1;
    step();
    chk("pop1_level", 32'(level), 32'd3);
    chk("pop1_I", 32'(I), 32'h4);
    chk("pop1_rdy", 32'(in_ready), 32'd1);
    step();
    chk("push5_level", 32'(level), 32'd3);
    chk("push5_I", 32'(I), 32'h2);
    drive(1'b0, 1'b0, 2'd0);
    step();
    chk("order_I3", 32'(I), 32'h1);
    step();
    chk("order_I4", 32'(I), 32'h4);
    chk("order_l4", 32'(level), 32'd1);
    step();
    chk("order_empty", 32'(out_valid), 32'd0);
    chk("order_null", 32'(null_cnt), 32'd0);

    // null words interleaved with real ones
    drive(1'b1, 1'b0, 2'd3); step();
    chk("nul1_cnt", 32'(null_cnt), 32'd1);
    chk("nul1_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 1'b1, 2'd1); step();
    chk("nul2_I", 32'(I), 32'h2);
    chk("nul2_cnt", 32'(null_cnt), 32'd1);
    drive(1'b1, 1'b0, 2'bxx); step();
    chk("nul3_valid", 32'(out_valid), 32'd0);
    chk("nul3_cnt", 32'(null_cnt), 32'd2);
    drive(1'b1, 1'b0, 2'd3); step();
    chk("nul4_cnt", 32'(null_cnt), 32'd3);
    chk("nul4_level", 32'(level), 32'd0);
    drive(1'b1, 1'b1, 2'd2); step();
    chk("nul5_I", 32'(I), 32'h4);
    chk("nul5_cnt", 32'(null_cnt), 32'd3);
    drive(1'b0, 1'b0, 2'd0); step();

    // a null word is refused while full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'(i));
      step();
    end
    chk("full2_level", 32'(level), 32'd4);
    drive(1'b1, 1'b0, 2'd3); step();
    chk("full_null_cnt", 32'(null_cnt), 32'd3);
    chk("full_null_lvl", 32'(level), 32'd4);
    drive(1'b0, 1'b0, 2'd0);
    out_ready = 1'b1;
    step();
    step();
    chk("lvl2_level", 32'(level), 32'd2);
    chk("lvl2_I", 32'(I), 32'h4);

    // sustained push+pop at level 2 across pointer wrap
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b1, yl[k]);
      step();
      e = (k == 0) ? 4'h8 : (4'b0001 << yl[k-1]);
      chk("thru_I", 32'(I), 32'(e));
      chk("thru_level", 32'(level), 32'd2);
    end

    // async reset with three entries queued
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 2'd0); step();
    drive(1'b0, 1'b0, 2'd0);
    chk("pre_rst_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_I", 32'(I), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_rdy", 32'(in_ready), 32'd1);
    chk("arst_null", 32'(null_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
    step();

    // 2-bit null counter saturates at 3
    b_in_valid = 1'b1;
    b_V        = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b_Y = 2'(k);
      step();
      chk("sat_cnt", 32'(b_null_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
      chk("sat_level", 32'(b_level), 32'd0);
    end
    b_in_valid = 1'b0;
    chk("sat_valid", 32'(b_out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
